fetch_issue_unit: RTL and testbench
===================================

Name: fetch_issue_unit

Overview:
- Fetch/issue stage sitting directly downstream of the program counter.
- Samples the PC value, reads the synchronous instruction memory, holds the instruction in an instruction register, and offers it to decode with a valid/ready handshake.
- Resolves jump instructions itself and drives the PC's advance strobe, jump flag and jump target, closing the PC loop one instruction at a time.

Parameters:
- LAST_ADDR, 27, highest legal instruction address; program end.
- ADDR_W, 16, PC/address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- run  input  1  start request; sampled in IDLE.
- pc_in  input  16  current PC value from the program counter.
- imem_addr  output  16  instruction memory address.
- imem_en  output  1  memory read strobe; data returns on imem_rdata exactly 1 cycle later.
- imem_rdata  input  16  instruction word.
- zero_flag  input  1  ALU zero flag for conditional jumps.
- instr  output  16  instruction register to decode.
- instr_pc  output  16  address the instruction was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts.
- cpu_enable  output  1  one-cycle PC advance strobe.
- jump_flag  output  1  qualifies cpu_enable; PC loads next.
- next  output  16  jump target.
- halted  output  1  high in HALT.
- instr_count  output  16  issued-instruction counter.

Behaviour:
- Reset (reset_n low at a rising edge): state=IDLE; instr, instr_pc, imem_addr, next, instr_count=0; instr_valid, imem_en, cpu_enable, jump_flag, halted=0. Reset overrides everything, including mid-handshake.
- States: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH (1 cycle): imem_addr<=pc_in, imem_en=1 -> WAIT.
- WAIT (1 cycle): instr<=imem_rdata, instr_pc<=imem_addr -> ISSUE.
- ISSUE:
  - instr_valid=1; instr and instr_pc stable until handshake.
  - On instr_valid&&instr_ready: cpu_enable=1 for exactly that cycle, instr_count+=1 (saturates at 16'hFFFF).
  - Jump decode on instr:
    - opcode instr[15:12]=4'hC: unconditional jump.
    - opcode 4'hD: jump iff zero_flag=1 in the handshake cycle.
    - offset=instr[8:0], signed, sign-extended to 16 bits.
    - next = instr_pc + sext(offset), 16-bit two's-complement wrap.
    - jump_flag=1 with cpu_enable only when the jump is taken; otherwise next=0 and jump_flag=0.
  - Opcode 4'hF (HALT) -> HALT, cpu_enable=0, not counted.
  - Non-jump with instr_pc==LAST_ADDR -> HALT after the handshake.
  - Otherwise -> FETCH.
- HALT: halted=1, all strobes 0; leave only via reset.
- Timing:
  - Steady state is 3 cycles per instruction with ready tied high.
  - The PC updates at the handshake edge; FETCH samples the updated pc_in on the following edge.
- Boundaries:
  - instr_ready low holds ISSUE indefinitely; no strobes while stalled.
  - run dropping outside IDLE is ignored.
  - Taken jump from LAST_ADDR proceeds to FETCH (not HALT).

Optional Feature:
- FETCH_CLAMP_EN defined: a taken-jump target is clamped before driving next.
  - Negative result (bit15 set) -> 0.
  - Result > LAST_ADDR -> LAST_ADDR.
- Undefined: the raw wrapped 16-bit sum drives next unmodified.

Test Plan:
- Sequential run: reset, run=1, ROM all NOPs, PC model advancing, ready=1 -> cpu_enable every 3 cycles; instr_pc 0,1,…,27; halted=1 after address 27; instr_count=28.
- Unconditional jump: ROM[5]=16'hC1FD (offset −3) -> at handshake of instr_pc=5: jump_flag=1, next=2; next fetch imem_addr=2.
- Conditional jump: ROM[3]=16'hD004 with zero_flag=0 -> jump_flag=0, advance to 4; rerun with zero_flag=1 -> next=7, jump_flag=1.
- Stall: hold instr_ready=0 for 10 cycles in ISSUE -> instr_valid stays 1, instr stable, cpu_enable=0 throughout; a single pulse once ready=1.
- Clamp: ROM[20]=16'hC014 (offset +20) -> FETCH_CLAMP_EN: next=27; undefined: next=40.
- Reset mid-ISSUE: reset_n=0 while instr_valid=1 -> next edge all outputs 0, state IDLE, no cpu_enable pulse.

Source files
------------

// File: rtl/fetch_issue_unit_if.sv
// Fetch/issue bus: synchronous instruction-memory port plus the valid/ready issue channel to decode.
// master = fetch_issue_unit side, slave = memory/decode side.
interface fetch_issue_unit_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [15:0]       imem_rdata;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_addr, imem_en, instr, instr_pc, instr_valid,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_addr, imem_en, instr, instr_pc, instr_valid,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: fetches at pc_in, issues to decode, resolves jumps and strobes the PC.
// Optional macro FETCH_CLAMP_EN clamps taken-jump targets into [0, LAST_ADDR].
//
// state   | meaning
// IDLE    | waiting for run
// FETCH   | present pc_in to memory with read strobe
// WAIT    | capture returned word into instruction register
// ISSUE   | offer instruction to decode, resolve jump on handshake
// HALT    | program finished; leave only via reset
module fetch_issue_unit #(
  parameter int LAST_ADDR = 27,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_pc_in,
  input  logic              i_zero_flag,
  fetch_issue_unit_if.master bus,
  output logic              o_cpu_enable,
  output logic              o_jump_flag,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_halted,
  output logic [15:0]       o_instr_count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_HALT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [15:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [15:0]       r_instr_count;

  logic [3:0]        w_opcode;
  logic              w_is_halt, w_taken, w_hs;
  logic [ADDR_W-1:0] w_offset, w_sum, w_target;

  assign w_opcode  = r_instr[15:12];
  assign w_is_halt = (w_opcode == 4'hF);
  assign w_taken   = (w_opcode == 4'hC) || ((w_opcode == 4'hD) && i_zero_flag);
  assign w_offset  = {{(ADDR_W-9){r_instr[8]}}, r_instr[8:0]};
  assign w_sum     = r_instr_pc + w_offset;

`ifdef FETCH_CLAMP_EN
  always_comb begin
    w_target = w_sum;
    if (w_sum[ADDR_W-1])   w_target = '0;
    else if (w_sum > LAST) w_target = LAST;
  end
`else
  assign w_target = w_sum;
`endif

  // Reset gates the handshake so a reset cycle never leaks a PC strobe.
  assign w_hs = reset_n && (r_state == S_ISSUE) && !w_is_halt && bus.instr_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_run) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_is_halt) begin
          w_state_nxt = S_HALT;
        end else if (bus.instr_ready) begin
          if (!w_taken && (r_instr_pc == LAST)) w_state_nxt = S_HALT;
          else                                  w_state_nxt = S_FETCH;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory samples its address on the FETCH edge, so pc_in is forwarded while in FETCH.
  assign bus.imem_en     = (r_state == S_FETCH);
  assign bus.imem_addr   = (r_state == S_FETCH) ? i_pc_in : r_imem_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = (r_state == S_ISSUE) && !w_is_halt;
  assign o_cpu_enable    = w_hs;
  assign o_jump_flag     = w_hs && w_taken;
  assign o_next          = (w_hs && w_taken) ? w_target : '0;
  assign o_halted        = (r_state == S_HALT);
  assign o_instr_count   = r_instr_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_imem_addr   <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH) r_imem_addr <= i_pc_in;
      if (r_state == S_WAIT) begin
        r_instr    <= bus.imem_rdata;
        r_instr_pc <= r_imem_addr;
      end
      if (w_hs && (r_instr_count != 16'hFFFF)) r_instr_count <= r_instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Scoreboard bench for fetch_issue_unit: directed ROM programs, PC model, queue of expected issues.
module tb_fetch_issue_unit;
  localparam int LAST = 27;
`ifdef FETCH_CLAMP_EN
  localparam logic [15:0] CLAMP_TGT = 16'd27;
`else
  localparam logic [15:0] CLAMP_TGT = 16'd40;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        zero_flag = 1'b0;
  logic [15:0] pc;
  logic        cpu_enable, jump_flag, halted;
  logic [15:0] next_t, instr_count;
  logic [15:0] rom [0:63];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_hs = -1;
  bit cad_en = 1'b0;

  typedef struct {
    logic [15:0] pc;
    logic        jf;
    logic [15:0] nx;
  } exp_t;
  exp_t q[$];

  fetch_issue_unit_if #(.ADDR_W(16)) bus();

  fetch_issue_unit #(.LAST_ADDR(LAST), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_run(run), .i_pc_in(pc), .i_zero_flag(zero_flag),
    .bus(bus), .o_cpu_enable(cpu_enable), .o_jump_flag(jump_flag), .o_next(next_t),
    .o_halted(halted), .o_instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr[5:0]];
    if (!reset_n)        pc <= 16'd0;
    else if (cpu_enable) pc <= jump_flag ? next_t : pc + 16'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Monitor: every PC strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (cpu_enable === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got instr_pc %0h expected no issue", bus.instr_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("issue_pc", bus.instr_pc, e.pc);
        chk("issue_jump_flag", jump_flag, e.jf);
        chk("issue_next", next_t, e.nx);
      end
      if (cad_en && last_hs >= 0) chk("cadence", cyc - last_hs, 3);
      last_hs = cyc;
    end
  end

  task automatic push(input logic [15:0] p, input logic j, input logic [15:0] n);
    exp_t e;
    e.pc = p; e.jf = j; e.nx = n;
    q.push_back(e);
  endtask

  task automatic push_seq(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push(16'(i), 1'b0, 16'd0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    step(1);
    reset_n = 1'b1;
    q.delete();
    last_hs = -1;
  endtask

  task automatic start();
    run = 1'b1;
    step(1);
    run = 1'b0;
  endtask

  task automatic wait_empty(input string nm, input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) step(1);
    chk(nm, q.size(), 0);
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && halted !== 1'b1; i++) step(1);
    chk("halt_reached", halted, 1);
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && bus.instr_valid !== 1'b1; i++) step(1);
    chk("valid_reached", bus.instr_valid, 1);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid"}, bus.instr_valid, 0);
    chk({nm, "_instr"}, bus.instr, 0);
    chk({nm, "_instr_pc"}, bus.instr_pc, 0);
    chk({nm, "_imem_addr"}, bus.imem_addr, 0);
    chk({nm, "_imem_en"}, bus.imem_en, 0);
    chk({nm, "_cpu_enable"}, cpu_enable, 0);
    chk({nm, "_jump_flag"}, jump_flag, 0);
    chk({nm, "_next"}, next_t, 0);
    chk({nm, "_halted"}, halted, 0);
    chk({nm, "_count"}, instr_count, 0);
  endtask

  logic [15:0] held_instr;

  initial begin
    bus.instr_ready = 1'b1;
    clear_rom();
    step(2);
    check_all_zero("reset");
    do_reset();

    // Sequential NOP program to the end, 3-cycle cadence.
    push_seq(0, LAST);
    cad_en = 1'b1;
    start();
    wait_halt(200);
    cad_en = 1'b0;
    chk("seq_count", instr_count, 28);
    chk("seq_drained", q.size(), 0);
    step(6);
    chk("seq_halt_hold", halted, 1);
    chk("seq_halt_strobe", cpu_enable, 0);

    // HALT opcode stops without counting.
    clear_rom();
    rom[2] = 16'hF000;
    do_reset();
    push_seq(0, 1);
    start();
    wait_halt(50);
    chk("halt_op_count", instr_count, 2);
    chk("halt_op_valid", bus.instr_valid, 0);

    // Unconditional backward jump 5 -> 2, then reset mid-ISSUE.
    clear_rom();
    rom[5] = 16'hC1FD;
    do_reset();
    push_seq(0, 4);
    push(16'd5, 1'b1, 16'd2);
    push_seq(2, 4);
    push(16'd5, 1'b1, 16'd2);
    push(16'd2, 1'b0, 16'd0);
    start();
    wait_empty("jump_drain", 100);
    bus.instr_ready = 1'b0;
    wait_valid(10);
    chk("jump_after_pc", bus.instr_pc, 3);
    reset_n = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_strobe", cpu_enable, 0);
    step(1);
    check_all_zero("rst_mid");
    reset_n = 1'b1;
    step(3);
    chk("rst_mid_idle", bus.instr_valid, 0);
    chk("rst_mid_idle_en", bus.imem_en, 0);

    // Conditional jump not taken, with a stall.
    clear_rom();
    rom[3] = 16'hD004;
    zero_flag = 1'b0;
    do_reset();
    push_seq(0, 2);
    push(16'd3, 1'b0, 16'd0);
    push(16'd4, 1'b0, 16'd0);
    start();
    wait_empty("cjmp_nt_drain", 100);
    bus.instr_ready = 1'b0;
    wait_valid(10);
    chk("stall_pc", bus.instr_pc, 5);
    held_instr = bus.instr;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_instr", bus.instr, held_instr);
      chk("stall_strobe", cpu_enable, 0);
    end
    push(16'd5, 1'b0, 16'd0);
    bus.instr_ready = 1'b1;
    wait_empty("stall_release", 10);
    bus.instr_ready = 1'b0;

    // Conditional jump taken.
    zero_flag = 1'b1;
    do_reset();
    bus.instr_ready = 1'b1;
    push_seq(0, 2);
    push(16'd3, 1'b1, 16'd7);
    push(16'd7, 1'b0, 16'd0);
    start();
    wait_empty("cjmp_t_drain", 100);
    bus.instr_ready = 1'b0;
    zero_flag = 1'b0;

    // Forward jump past the end: raw or clamped target.
    clear_rom();
    rom[20] = 16'hC014;
    do_reset();
    bus.instr_ready = 1'b1;
    push_seq(0, 19);
    push(16'd20, 1'b1, CLAMP_TGT);
    push(CLAMP_TGT, 1'b0, 16'd0);
    start();
    wait_empty("clamp_drain", 200);
    bus.instr_ready = 1'b0;

    // Taken jump from the last address keeps running.
    clear_rom();
    rom[LAST] = 16'hC1FF;
    do_reset();
    bus.instr_ready = 1'b1;
    push_seq(0, 26);
    push(16'd27, 1'b1, 16'd26);
    push(16'd26, 1'b0, 16'd0);
    push(16'd27, 1'b1, 16'd26);
    start();
    wait_empty("last_jump_drain", 200);
    chk("last_jump_not_halted", halted, 0);
    bus.instr_ready = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
